note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 149 ++++++++++++++
 tb/tb_note_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - 16-entry note sequencer playing {note, dur} entries in ticks of TICK_DIV clocks
// Define NOTE_SEQUENCER_GAP_EN to insert a one-tick silent gap after every note.
module note_sequencer #(
  parameter int TICK_DIV = 1000000,
  parameter int DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_note,
  input  logic [7:0] wr_dur,
  output logic [7:0] note_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
`ifdef NOTE_SEQUENCER_GAP_EN
  localparam logic [1:0] S_GAP   = 2'd3;
`endif

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_dur_cnt;
  logic [7:0]    r_note;
  logic [3:0]    r_step;
  logic          r_done;
  logic [5:0]    r_mem_note [DEPTH];
  logic [7:0]    r_mem_dur  [DEPTH];

  logic          w_tick;
  logic          w_seq_adv;
  logic          w_last;
  logic [5:0]    w_fetch_note;
  logic [7:0]    w_fetch_dur;

  assign w_tick       = (r_presc == TICK_LAST);
  assign w_last       = (r_step == 4'(DEPTH - 1));
  assign w_fetch_note = r_mem_note[r_step];
  assign w_fetch_dur  = r_mem_dur[r_step];

  // w_seq_adv marks the end of an entry's full period (note, plus gap when enabled)
`ifdef NOTE_SEQUENCER_GAP_EN
  assign w_seq_adv = (r_state == S_GAP) && w_tick;
`else
  assign w_seq_adv = (r_state == S_PLAY) && w_tick && (r_dur_cnt == 8'd1);
`endif

  assign note_out = r_note;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign step     = r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_note[i] <= '0;
        r_mem_dur[i]  <= '0;
      end
    end else if (wr_en) begin
      r_mem_note[wr_addr] <= wr_note;
      r_mem_dur[wr_addr]  <= wr_dur;
    end
  end

  // PLAY and GAP share bit 1 of the encoding; the prescaler runs only there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (r_state[1]) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end else begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dur_cnt <= '0;
      r_note    <= '0;
      r_step    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_note  <= '0;
        r_step  <= '0;
      end else if (w_seq_adv) begin
        r_note <= '0;
        if (!w_last) begin
          r_step  <= r_step + 4'd1;
          r_state <= S_FETCH;
        end else if (loop) begin
          r_step  <= '0;
          r_state <= S_FETCH;
        end else begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !stop) begin
              r_state <= S_FETCH;
              r_step  <= '0;
            end
          end
          S_FETCH: begin
            if (w_fetch_dur == 8'd0) begin
              r_state <= S_IDLE;
              r_note  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_dur_cnt <= w_fetch_dur;
              r_note    <= ((w_fetch_note >= 6'd1) && (w_fetch_note <= 6'd36)) ?
                           {2'b00, w_fetch_note} : 8'd0;
              r_state   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (w_tick) begin
              r_dur_cnt <= r_dur_cnt - 8'd1;
`ifdef NOTE_SEQUENCER_GAP_EN
              if (r_dur_cnt == 8'd1) begin
                r_note  <= '0;
                r_state <= S_GAP;
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - bench for note_sequencer: cycle-countdown model, directed and random stimulus
module tb_note_sequencer;
  localparam int TD = 4;
`ifdef NOTE_SEQUENCER_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_SOUND = 2, M_REST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [5:0] wr_note = '0;
  logic [7:0] wr_dur = '0;
  logic [7:0] note_out;
  logic       busy, done;
  logic [3:0] step;

  note_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .note_out(note_out), .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  // model: a mode plus the number of clock cycles left in it
  int m_mode = M_IDLE, m_left = 0, m_step = 0, m_note = 0;
  bit m_done = 1'b0;
  int mem_n [16] = '{default: 0};
  int mem_d [16] = '{default: 0};

  function automatic int audible(input int n);
    return (n >= 1 && n <= 36) ? n : 0;
  endfunction

  task automatic m_next_entry();
    if (m_step < 15) begin
      m_step++;
      m_mode = M_LOAD;
    end else if (loop) begin
      m_step = 0;
      m_mode = M_LOAD;
    end else begin
      m_mode = M_IDLE;
      m_done = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_left = 0; m_step = 0; m_note = 0; m_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_n[i] = 0;
        mem_d[i] = 0;
      end
    end else begin
      m_done = 1'b0;
      if (m_mode != M_IDLE && stop) begin
        m_mode = M_IDLE; m_note = 0; m_step = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (start && !stop) begin m_mode = M_LOAD; m_step = 0; end
          M_LOAD: begin
            if (mem_d[m_step] == 0) begin
              m_mode = M_IDLE; m_note = 0; m_done = 1'b1;
            end else begin
              m_note = audible(mem_n[m_step]);
              m_left = mem_d[m_step] * TD;
              m_mode = M_SOUND;
            end
          end
          M_SOUND: begin
            m_left--;
            if (m_left == 0) begin
              m_note = 0;
              if (GAP) begin m_mode = M_REST; m_left = TD; end
              else m_next_entry();
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) m_next_entry();
          end
        endcase
      end
      if (wr_en) begin
        mem_n[wr_addr] = int'(wr_note);
        mem_d[wr_addr] = int'(wr_dur);
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int snd [256];
  int busy_cnt, done_cnt, sound_cnt, max_step, prev_step;
  bit saw_wrap;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic clr();
    for (int i = 0; i < 256; i++) snd[i] = 0;
    busy_cnt = 0; done_cnt = 0; sound_cnt = 0; max_step = 0; saw_wrap = 1'b0; prev_step = 0;
  endtask

  // advance one clock and compare every output against the model
  task automatic cycle();
    @(negedge clk);
    chk("note_out", int'(note_out), m_note);
    chk("busy", int'(busy), int'(m_mode != M_IDLE));
    chk("done", int'(done), int'(m_done));
    chk("step", int'(step), m_step);
    snd[note_out]++;
    if (note_out != 8'd0) sound_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (busy && int'(step) > max_step) max_step = int'(step);
    if (busy && prev_step == 15 && step == 4'd0) saw_wrap = 1'b1;
    prev_step = int'(step);
  endtask

  task automatic wr(input int a, input int n, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_note = 6'(n); wr_dur = 8'(d);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      cycle();
      k++;
    end
    chk("run_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    clr();
    cycle(); cycle();
    chk("rst_note", int'(note_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step), 0);
    rst_n = 1'b1;

    // single note then end marker
    wr(0, 10, 2); wr(1, 0, 0);
    clr(); go(); run_idle(40);
    chk("s1_note10_cycles", snd[10], 8);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_busy_cycles", busy_cnt, GAP ? 14 : 10);

    // full table, no loop
    for (int i = 0; i < 16; i++) wr(i, i + 1, 1);
    loop = 1'b0;
    clr(); go(); run_idle(300);
    for (int k = 1; k <= 16; k++) chk($sformatf("s2_note%0d_cycles", k), snd[k], 4);
    chk("s2_max_step", max_step, 15);
    chk("s2_done_cnt", done_cnt, 1);
    chk("s2_busy_cycles", busy_cnt, GAP ? 144 : 80);

    // looping, then stop
    loop = 1'b1;
    clr(); go();
    repeat (GAP ? 160 : 100) cycle();
    stop = 1'b1; cycle(); stop = 1'b0; loop = 1'b0;
    chk("s3_wrap_seen", int'(saw_wrap), 1);
    chk("s3_stop_note", int'(note_out), 0);
    chk("s3_stop_busy", int'(busy), 0);
    chk("s3_stop_step", int'(step), 0);
    chk("s3_done_cnt", done_cnt, 0);

    // out-of-range note is a rest
    wr(0, 50, 1); wr(1, 0, 0);
    clr(); go(); run_idle(40);
    chk("s4_sound_cycles", sound_cnt, 0);
    chk("s4_done_cnt", done_cnt, 1);
    chk("s4_busy_cycles", busy_cnt, GAP ? 10 : 6);

    // rewriting the sounding entry only affects its next fetch
    wr(0, 12, 2);
    clr(); go();
    repeat (3) cycle();
    wr(0, 13, 1);
    run_idle(40);
    chk("s5_note12_cycles", snd[12], 8);
    chk("s5_note13_cycles", snd[13], 0);
    clr(); go(); run_idle(40);
    chk("s5_note13_next", snd[13], 4);

    // asynchronous reset mid-note
    wr(0, 20, 3);
    clr(); go();
    repeat (5) cycle();
    chk("s6_pre_rst_note", int'(note_out), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_note", int'(note_out), 0);
    chk("s6_async_busy", int'(busy), 0);
    cycle();
    rst_n = 1'b1;
    clr(); go(); run_idle(20);
    chk("s6_rerun_sound", sound_cnt, 0);
    chk("s6_rerun_done", done_cnt, 1);
    chk("s6_rerun_busy", busy_cnt, 1);

    // two short notes
    wr(0, 5, 1); wr(1, 7, 1); wr(2, 0, 0);
    clr(); go(); run_idle(60);
    chk("s7_note5_cycles", snd[5], 4);
    chk("s7_note7_cycles", snd[7], 4);
    chk("s7_busy_cycles", busy_cnt, GAP ? 19 : 11);
    chk("s7_done_cnt", done_cnt, 1);

    // random traffic, checked cycle by cycle against the model
    for (int it = 0; it < 1500; it++) begin
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_note = 6'($urandom_range(0, 63));
      wr_dur  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 31) == 0) loop = ~loop;
      cycle();
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
